// File: rtl/avalon_pio_master_if.sv
// Bundles the local command/response handshake and the Avalon-MM bus signals
// of the PIO master so the design and its environment connect through one port.
interface avalon_pio_master_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_error;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [DATA_W-1:0] avm_writedata;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_waitrequest;
   logic              busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
             avm_address, avm_read, avm_write, avm_writedata, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
             avm_address, avm_read, avm_write, avm_writedata, busy
   );
endinterface

// File: rtl/avalon_pio_master.sv
// Single-outstanding Avalon-MM master for the PIO slave: takes one local command,
// runs the bus cycle with waitrequest/timeout handling, returns a one-cycle response.
module avalon_pio_master #(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT      = 255
) (
   input logic                 clk,
   input logic                 reset_n,
   avalon_pio_master_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE_WR,
      S_ISSUE_RD,
      S_WAIT_RD,
      S_RESP
   } state_t;

   localparam logic [2:0] LAT_INIT   = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
   localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

   state_t            r_state;
   logic              r_cmd_ready;
   logic              r_busy;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_error;
   logic [ADDR_W-1:0] r_avm_address;
   logic              r_avm_read;
   logic              r_avm_write;
   logic [DATA_W-1:0] r_avm_writedata;
   logic [7:0]        r_stall;
   logic [2:0]        r_lat;

   assign bus.cmd_ready     = r_cmd_ready;
   assign bus.busy          = r_busy;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_rdata     = r_rsp_rdata;
   assign bus.rsp_error     = r_rsp_error;
   assign bus.avm_address   = r_avm_address;
   assign bus.avm_read      = r_avm_read;
   assign bus.avm_write     = r_avm_write;
   assign bus.avm_writedata = r_avm_writedata;

   // A stall that reaches the limit only errors if waitrequest is still high on that edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_cmd_ready     <= 1'b0;
         r_busy          <= 1'b0;
         r_rsp_valid     <= 1'b0;
         r_rsp_rdata     <= '0;
         r_rsp_error     <= 1'b0;
         r_avm_address   <= '0;
         r_avm_read      <= 1'b0;
         r_avm_write     <= 1'b0;
         r_avm_writedata <= '0;
         r_stall         <= '0;
         r_lat           <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_cmd_ready   <= 1'b0;
                  r_busy        <= 1'b1;
                  r_stall       <= '0;
                  r_avm_address <= bus.cmd_addr;
                  if (bus.cmd_write) begin
                     r_avm_write     <= 1'b1;
                     r_avm_writedata <= bus.cmd_wdata;
                     r_state         <= S_ISSUE_WR;
                  end else begin
                     r_avm_read      <= 1'b1;
                     r_avm_writedata <= '0;
                     r_state         <= S_ISSUE_RD;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end

            S_ISSUE_WR: begin
               if (!bus.avm_waitrequest) begin
                  r_avm_write <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_error <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (r_stall == STALL_LAST) begin
                  r_avm_write <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_error <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_stall <= r_stall + 8'd1;
               end
            end

            S_ISSUE_RD: begin
               if (!bus.avm_waitrequest) begin
                  r_avm_read <= 1'b0;
                  if (READ_LATENCY == 0) begin
                     r_rsp_rdata <= bus.avm_readdata;
                     r_rsp_error <= 1'b0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end else begin
                     r_lat   <= LAT_INIT;
                     r_state <= S_WAIT_RD;
                  end
               end else if (r_stall == STALL_LAST) begin
                  r_avm_read  <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_error <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_stall <= r_stall + 8'd1;
               end
            end

            S_WAIT_RD: begin
               if (r_lat == 3'd0) begin
                  r_rsp_rdata <= bus.avm_readdata;
                  r_rsp_error <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_lat <= r_lat - 3'd1;
               end
            end

            S_RESP: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_pio_master.sv
// Randomized scoreboard bench for avalon_pio_master: a transaction-level model
// predicts each response and bus window; a monitor pops and compares responses.
module tb_avalon_pio_master;

   localparam int ADDR_W = 2;
   localparam int DATA_W = 32;
   localparam int RL     = 1;
   localparam int TMO    = 8;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          rspCyc;
   } rsp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   assertCount = 0;
   int   failCount = 0;
   rsp_t expQ[$];
   logic [31:0] lastRdata = '0;
   logic        lastErr = 1'b0;

   avalon_pio_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   avalon_pio_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Response monitor: every rsp_valid must match the oldest predicted response
   always @(negedge clk) begin
      rsp_t e;
      if (!reset_n) begin
         lastRdata = '0;
         lastErr   = 1'b0;
      end else begin
         checkOutput("read_write_exclusive", 64'(bus.avm_read && bus.avm_write), 64'd0);
         if (bus.rsp_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_rsp_valid", 64'd1, 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("rsp_cycle", 64'(cyc), 64'(e.rspCyc));
               checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
               checkOutput("rsp_error", 64'(bus.rsp_error), 64'(e.err));
               lastRdata = e.rdata;
               lastErr   = e.err;
            end
         end else begin
            checkOutput("rsp_hold", {31'd0, bus.rsp_error, bus.rsp_rdata}, {31'd0, lastErr, lastRdata});
         end
      end
   end

   task automatic driveJunkCmd();
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = 2'($urandom_range(0, 3));
      bus.cmd_wdata = $urandom;
   endtask

   task automatic applyStimulus(input bit isWrite, input logic [1:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int stall, input int idleGap);
      int c;
      int rq;
      int rspOff;
      bit err;
      repeat (idleGap) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         checkOutput("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
         checkOutput("idle_busy", 64'(bus.busy), 64'd0);
      end
      @(negedge clk);
      checkOutput("cmd_ready_at_present", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid       = 1'b1;
      bus.cmd_write       = isWrite;
      bus.cmd_addr        = addr;
      bus.cmd_wdata       = wdata;
      bus.avm_waitrequest = 1'($urandom_range(0, 1));
      bus.avm_readdata    = $urandom;
      c      = cyc;
      err    = (stall >= TMO);
      rq     = err ? TMO : stall + 1;
      rspOff = rq + ((!isWrite && !err) ? RL : 0) + 1;
      expQ.push_back('{rdata: (isWrite || err) ? 32'd0 : rdata, err: err, rspCyc: c + rspOff});
      for (int k = 1; k <= rspOff; k++) begin
         bit inReq;
         @(negedge clk);
         inReq = (k <= rq);
         checkOutput("avm_write", 64'(bus.avm_write), 64'(isWrite && inReq));
         checkOutput("avm_read", 64'(bus.avm_read), 64'(!isWrite && inReq));
         if (inReq) begin
            checkOutput("avm_address", 64'(bus.avm_address), 64'(addr));
            checkOutput("avm_writedata", 64'(bus.avm_writedata), 64'(isWrite ? wdata : 32'd0));
         end
         checkOutput("busy_in_flight", 64'(bus.busy), 64'd1);
         checkOutput("cmd_ready_in_flight", 64'(bus.cmd_ready), 64'd0);
         bus.avm_waitrequest = inReq ? (k <= stall) : 1'($urandom_range(0, 1));
         bus.avm_readdata    = (!isWrite && !err && k == rq + RL) ? rdata : $urandom;
         driveJunkCmd();
      end
   endtask

   task automatic resetMidTransaction();
      @(negedge clk);
      checkOutput("cmd_ready_before_abort", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid       = 1'b1;
      bus.cmd_write       = 1'b0;
      bus.cmd_addr        = 2'd1;
      bus.avm_waitrequest = 1'b1;
      repeat (3) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         checkOutput("abort_avm_read_stalled", 64'(bus.avm_read), 64'd1);
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_avm_read", 64'(bus.avm_read), 64'd0);
      checkOutput("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      checkOutput("abort_busy", 64'(bus.busy), 64'd0);
      checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      checkOutput("release_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      checkOutput("release_busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int stall;
      int sel;
      bus.cmd_valid       = 1'b0;
      bus.cmd_write       = 1'b0;
      bus.cmd_addr        = '0;
      bus.cmd_wdata       = '0;
      bus.avm_readdata    = '0;
      bus.avm_waitrequest = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      checkOutput("reset_busy", 64'(bus.busy), 64'd0);
      checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      checkOutput("reset_rsp_error", 64'(bus.rsp_error), 64'd0);
      checkOutput("reset_avm_read", 64'(bus.avm_read), 64'd0);
      checkOutput("reset_avm_write", 64'(bus.avm_write), 64'd0);
      checkOutput("reset_avm_address", 64'(bus.avm_address), 64'd0);
      checkOutput("reset_avm_writedata", 64'(bus.avm_writedata), 64'd0);
      bus.cmd_valid = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("first_edge_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      checkOutput("first_edge_busy", 64'(bus.busy), 64'd0);
      bus.cmd_valid = 1'b0;

      applyStimulus(1'b1, 2'd0, 32'h8001_00A5, 32'd0, 0, 0);
      applyStimulus(1'b0, 2'd0, 32'd0, 32'h0000_0F3C, 0, 0);
      applyStimulus(1'b1, 2'd2, 32'hDEAD_BEEF, 32'd0, 5, 1);
      applyStimulus(1'b0, 2'd1, 32'd0, 32'h1234_5678, 100, 0);
      applyStimulus(1'b0, 2'd3, 32'd0, 32'hCAFE_F00D, TMO - 1, 0);
      applyStimulus(1'b1, 2'd2, 32'h5A5A_A5A5, 32'd0, TMO, 2);
      applyStimulus(1'b0, 2'd2, 32'd0, 32'h0BAD_CAFE, TMO + 1, 0);
      resetMidTransaction();

      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 5)      stall = 0;
         else if (sel < 8) stall = $urandom_range(1, 4);
         else              stall = $urandom_range(TMO - 2, TMO + 2);
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                       stall, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
      end

      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("pending_responses", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
